// File: rtl/pe_pkg.sv
// pe_pkg: shared defaults, saturation limits and parameter checks for the
// pe_acc multiply-accumulate processing element.
package pe_pkg;

  localparam int PE_BIT_WIDTH = 8;
  localparam int PE_ACC_WIDTH = 24;
  localparam int PE_MUL_LAT   = 3;

  // Largest accumulator value, returned wide and sliced by the caller.
  function automatic logic [63:0] acc_max(input int aw, input bit sgn);
    acc_max = sgn ? ((64'd1 << (aw - 1)) - 64'd1) : ((64'd1 << aw) - 64'd1);
  endfunction

  // Smallest accumulator value; low aw bits form the two's-complement minimum.
  function automatic logic [63:0] acc_min(input int aw, input bit sgn);
    acc_min = sgn ? ~((64'd1 << (aw - 1)) - 64'd1) : 64'd0;
  endfunction

  // Accumulator must hold a full product; multiplier needs at least one stage.
  function automatic bit cfg_ok(input int bw, input int aw, input int ml);
    cfg_ok = (bw >= 1) && (aw >= 2 * bw) && (aw <= 63) && (ml >= 1);
  endfunction

endpackage

// File: rtl/pe_mul.sv
// pe_mul: pipelined BIT_WIDTH x BIT_WIDTH multiplier with clock enable.
// MUL_LAT register stages; a valid bit and a generic sideband ride alongside.
module pe_mul import pe_pkg::*; #(
  parameter int BIT_WIDTH = PE_BIT_WIDTH,
  parameter int MUL_LAT   = PE_MUL_LAT,
  parameter bit SIGNED    = 1'b1,
  parameter int SB_W      = 2
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic                   i_vld,
  input  logic [BIT_WIDTH-1:0]   i_a,
  input  logic [BIT_WIDTH-1:0]   i_b,
  input  logic [SB_W-1:0]        i_sb,
  output logic                   o_vld,
  output logic [2*BIT_WIDTH-1:0] o_p,
  output logic [SB_W-1:0]        o_sb
);
  localparam int PW = 2 * BIT_WIDTH;

  logic [PW-1:0]               w_a, w_b, w_prod;
  logic [MUL_LAT:1]            r_vld_pipe;
  logic [MUL_LAT:1][PW-1:0]    r_p;
  logic [MUL_LAT:1][SB_W-1:0]  r_sb;

  // Extend to product width first so the low PW bits are exact either way.
  assign w_a    = SIGNED ? {{BIT_WIDTH{i_a[BIT_WIDTH-1]}}, i_a} : {{BIT_WIDTH{1'b0}}, i_a};
  assign w_b    = SIGNED ? {{BIT_WIDTH{i_b[BIT_WIDTH-1]}}, i_b} : {{BIT_WIDTH{1'b0}}, i_b};
  assign w_prod = w_a * w_b;

  // Product and sideband shift register; frozen when i_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_p        <= '0;
      r_sb       <= '0;
    end else if (i_en) begin
      r_vld_pipe[1] <= i_vld;
      r_p[1]        <= w_prod;
      r_sb[1]       <= i_sb;
      for (int s = 2; s <= MUL_LAT; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_p[s]        <= r_p[s-1];
        r_sb[s]       <= r_sb[s-1];
      end
    end
  end

  assign o_vld = r_vld_pipe[MUL_LAT];
  assign o_p   = r_p[MUL_LAT];
  assign o_sb  = r_sb[MUL_LAT];

endmodule

// File: rtl/pe_acc.sv
// pe_acc: multiply-accumulate PE. Beats grouped by first/last flags; one
// registered partial sum per group, held under downstream back-pressure.
// Optional clamping of every accumulate step is built when PE_SAT_EN is defined.
module pe_acc import pe_pkg::*; #(
  parameter int BIT_WIDTH = PE_BIT_WIDTH,
  parameter int ACC_WIDTH = PE_ACC_WIDTH,
  parameter int MUL_LAT   = PE_MUL_LAT,
  parameter bit SIGNED    = 1'b1
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] i_data,
  input  logic [BIT_WIDTH-1:0] i_weight,
  input  logic [ACC_WIDTH-1:0] i_psum,
  input  logic                 i_first,
  input  logic                 i_last,
  input  logic                 i_vld,
  output logic                 o_rdy,
  output logic [ACC_WIDTH-1:0] o_psum,
  output logic                 o_psum_vld,
  input  logic                 i_psum_rdy,
  output logic                 o_sat
);
  localparam int PW = 2 * BIT_WIDTH;

  if (!cfg_ok(BIT_WIDTH, ACC_WIDTH, MUL_LAT)) begin : g_bad_cfg
    $error("pe_acc: need ACC_WIDTH >= 2*BIT_WIDTH and MUL_LAT >= 1");
  end

  logic                 w_en;
  logic                 r_vld1, r_first, r_last;
  logic [BIT_WIDTH-1:0] r_data, r_weight;
  logic [ACC_WIDTH-1:0] r_seed;
  logic                 w_mvld, w_first, w_last;
  logic [PW-1:0]        w_prod;
  logic [ACC_WIDTH+1:0] w_msb;
  logic [ACC_WIDTH-1:0] w_seed, w_base, w_pext, w_res;
  logic [ACC_WIDTH-1:0] r_acc, r_psum;
  logic                 r_psum_vld;

  // The whole pipeline advances only when the output slot can move.
  assign w_en  = !(r_psum_vld && !i_psum_rdy);
  assign o_rdy = w_en;

  // Operand capture stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld1   <= 1'b0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_data   <= '0;
      r_weight <= '0;
      r_seed   <= '0;
    end else if (w_en) begin
      r_vld1   <= i_vld;
      r_first  <= i_first;
      r_last   <= i_last;
      r_data   <= i_data;
      r_weight <= i_weight;
      r_seed   <= i_psum;
    end
  end

  pe_mul #(
    .BIT_WIDTH (BIT_WIDTH),
    .MUL_LAT   (MUL_LAT),
    .SIGNED    (SIGNED),
    .SB_W      (ACC_WIDTH + 2)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_en),
    .i_vld (r_vld1),
    .i_a   (r_data),
    .i_b   (r_weight),
    .i_sb  ({r_first, r_last, r_seed}),
    .o_vld (w_mvld),
    .o_p   (w_prod),
    .o_sb  (w_msb)
  );

  assign {w_first, w_last, w_seed} = w_msb;

  // Product extended to accumulator width per signedness.
  if (ACC_WIDTH > PW) begin : g_ext
    assign w_pext = {{(ACC_WIDTH-PW){SIGNED && w_prod[PW-1]}}, w_prod};
  end else begin : g_noext
    assign w_pext = w_prod;
  end

  // A first beat restarts from the seed, discarding any open partial.
  assign w_base = w_first ? w_seed : r_acc;

`ifdef PE_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(acc_max(ACC_WIDTH, SIGNED));
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(acc_min(ACC_WIDTH, SIGNED));

  logic [ACC_WIDTH:0] w_sum;
  logic               w_ovf, w_stk, r_stk, r_sat;

  // One extra bit exposes overflow; clamp toward the side it overflowed.
  always_comb begin
    if (SIGNED) begin
      w_sum = {w_base[ACC_WIDTH-1], w_base} + {w_pext[ACC_WIDTH-1], w_pext};
      w_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    end else begin
      w_sum = {1'b0, w_base} + {1'b0, w_pext};
      w_ovf = w_sum[ACC_WIDTH];
    end
    w_res = w_sum[ACC_WIDTH-1:0];
    if (w_ovf) w_res = (SIGNED && w_sum[ACC_WIDTH]) ? ACC_MIN : ACC_MAX;
    w_stk = (w_first ? 1'b0 : r_stk) | w_ovf;
  end

  // Sticky per-group clamp flag, published with the group result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stk <= 1'b0;
      r_sat <= 1'b0;
    end else if (w_en && w_mvld) begin
      if (w_last) begin
        r_sat <= w_stk;
        r_stk <= 1'b0;
      end else begin
        r_stk <= w_stk;
      end
    end
  end

  assign o_sat = r_sat;
`else
  assign w_res = w_base + w_pext;
  assign o_sat = 1'b0;
`endif

  // Accumulator and output register; a handshake with no new last drops valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc      <= '0;
      r_psum     <= '0;
      r_psum_vld <= 1'b0;
    end else if (w_en) begin
      r_psum_vld <= w_mvld && w_last;
      if (w_mvld) begin
        if (w_last) begin
          r_psum <= w_res;
          r_acc  <= '0;
        end else begin
          r_acc  <= w_res;
        end
      end
    end
  end

  assign o_psum     = r_psum;
  assign o_psum_vld = r_psum_vld;

endmodule

// File: tb/tb_pe_acc.sv
// tb_pe_acc: scoreboard bench for pe_acc. Three instances share one stimulus
// stream: 24-bit signed, 16-bit signed and 24-bit unsigned. Expectations
// follow PE_SAT_EN the same way the design does.
module tb_pe_acc;

  typedef struct packed {
    logic [23:0] ps;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data, weight;
  logic [23:0] psum;
  logic        first, last, vld, psum_rdy;
  logic [2:0]  rdy, ovld, osat;
  logic [23:0] ops0, ops2;
  logic [15:0] ops1;

  int   errs = 0;
  int   checks = 0;
  exp_t q0[$], q1[$], q2[$];

  longint m_acc [3];
  bit     m_stk [3];
  int     AW [3] = '{24, 16, 24};
  bit     SG [3] = '{1'b1, 1'b1, 1'b0};

  bit          hold [3];
  logic [23:0] hps [3];
  logic        hsat [3];

  always #5 clk = ~clk;

  pe_acc #(.BIT_WIDTH(8), .ACC_WIDTH(24), .MUL_LAT(3), .SIGNED(1'b1)) u_d0 (
    .clk(clk), .rst(rst), .i_data(data), .i_weight(weight), .i_psum(psum),
    .i_first(first), .i_last(last), .i_vld(vld), .o_rdy(rdy[0]), .o_psum(ops0),
    .o_psum_vld(ovld[0]), .i_psum_rdy(psum_rdy), .o_sat(osat[0]));

  pe_acc #(.BIT_WIDTH(8), .ACC_WIDTH(16), .MUL_LAT(3), .SIGNED(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .i_data(data), .i_weight(weight), .i_psum(psum[15:0]),
    .i_first(first), .i_last(last), .i_vld(vld), .o_rdy(rdy[1]), .o_psum(ops1),
    .o_psum_vld(ovld[1]), .i_psum_rdy(psum_rdy), .o_sat(osat[1]));

  pe_acc #(.BIT_WIDTH(8), .ACC_WIDTH(24), .MUL_LAT(3), .SIGNED(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .i_data(data), .i_weight(weight), .i_psum(psum),
    .i_first(first), .i_last(last), .i_vld(vld), .o_rdy(rdy[2]), .o_psum(ops2),
    .o_psum_vld(ovld[2]), .i_psum_rdy(psum_rdy), .o_sat(osat[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int i, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Reference: plain integer arithmetic on the accepted beat for each instance.
  task automatic model_beat();
    for (int i = 0; i < 3; i++) begin
      longint mask, a, b, seed, s, lo, hi;
      bit     cl, stk;
      exp_t   e;
      cl   = 1'b0;
      mask = (longint'(1) << AW[i]) - 1;
      a    = SG[i] ? longint'($signed(data))   : longint'(data);
      b    = SG[i] ? longint'($signed(weight)) : longint'(weight);
      seed = longint'(psum) & mask;
      if (SG[i] && seed >= (longint'(1) << (AW[i] - 1))) seed -= (longint'(1) << AW[i]);
      s = (first ? seed : m_acc[i]) + a * b;
`ifdef PE_SAT_EN
      lo = SG[i] ? -(longint'(1) << (AW[i] - 1)) : 0;
      hi = SG[i] ? (longint'(1) << (AW[i] - 1)) - 1 : mask;
      if (s > hi) begin s = hi; cl = 1'b1; end
      else if (s < lo) begin s = lo; cl = 1'b1; end
`else
      lo = 0;
      hi = 0;
      s = s & mask;
      if (SG[i] && s >= (longint'(1) << (AW[i] - 1))) s -= (longint'(1) << AW[i]);
`endif
      stk = (first ? 1'b0 : m_stk[i]) | cl;
      if (last) begin
        e.ps  = 24'(s & mask);
        e.sat = stk;
        push_exp(i, e);
        m_acc[i] = 0;
        m_stk[i] = 1'b0;
      end else begin
        m_acc[i] = s;
        m_stk[i] = stk;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0;
      m_stk[i] = 1'b0;
    end
  endtask

  // Present one beat; the model updates on the edge where it is accepted.
  task automatic send_beat(input logic [7:0] d, input logic [7:0] w, input logic [23:0] ps,
                           input logic f, input logic l, input bit rnd);
    bit acc;
    acc = 1'b0;
    data = d; weight = w; psum = ps; first = f; last = l; vld = 1'b1;
    if (rnd) psum_rdy = ($urandom_range(0, 3) != 0);
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      if (&rdy) begin
        model_beat();
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (!acc && rnd) psum_rdy = ($urandom_range(0, 1) != 0);
    end
    vld = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Cycles from the acceptance cycle until o_psum_vld of the 24-bit instance.
  task automatic wait_vld(output int n);
    n = 1;
    while (!ovld[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && ovld == 3'b000) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic mon(input int i, input logic v, input logic [23:0] ps, input logic s);
    exp_t e;
    bit   ok;
    if (hold[i]) begin
      chk($sformatf("hold_vld_d%0d", i), v, 1);
      chk($sformatf("hold_psum_d%0d", i), ps, hps[i]);
      chk($sformatf("hold_sat_d%0d", i), s, hsat[i]);
    end
    hold[i] = v && !psum_rdy;
    hps[i]  = ps;
    hsat[i] = s;
    if (v && psum_rdy) begin
      pop_exp(i, ok, e);
      if (!ok) chk($sformatf("unexpected_out_d%0d", i), ps, 32'hDEAD);
      else begin
        chk($sformatf("psum_d%0d", i), ps, e.ps);
        chk($sformatf("sat_d%0d", i), s, e.sat);
      end
    end
  endtask

  initial begin
    int n;
    logic [23:0] e1;
    logic        s1;
`ifdef PE_SAT_EN
    e1 = 24'h007FFF; s1 = 1'b1;
`else
    e1 = 24'h00BD03; s1 = 1'b0;
`endif
    rst = 1'b0; vld = 1'b0; first = 1'b0; last = 1'b0;
    data = '0; weight = '0; psum = '0; psum_rdy = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) hold[i] = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          mon(0, ovld[0], ops0, osat[0]);
          mon(1, ovld[1], {8'h00, ops1}, osat[1]);
          mon(2, ovld[2], ops2, osat[2]);
        end else begin
          for (int i = 0; i < 3; i++) hold[i] = 1'b0;
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", ovld, 0);
    chk("rst_psum", ops0, 0);
    chk("rst_sat", osat, 0);
    chk("rst_rdy", rdy, 3'b111);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single-beat group: 3 * -4 + 10
    send_beat(8'd3, 8'hFC, 24'd10, 1'b1, 1'b1, 1'b0);
    wait_vld(n);
    chk("single_lat", n, 5);
    chk("single_psum", ops0, 24'hFFFFFE);
    @(posedge clk); #1;
    chk("single_pulse", ovld[0], 0);

    // Four-beat back-to-back group
    for (int k = 1; k <= 4; k++)
      send_beat(8'(k), 8'd2, 24'd0, k == 1, k == 4, 1'b0);
    wait_vld(n);
    chk("grp4_lat", n, 5);
    chk("grp4_psum", ops0, 24'd20);
    drain();

    // 127*127 three times: clamps or wraps on the 16-bit instance
    for (int k = 0; k < 3; k++)
      send_beat(8'd127, 8'd127, 24'd0, k == 0, k == 2, 1'b0);
    wait_vld(n);
    chk("sat16_psum", {8'h00, ops1}, e1);
    chk("sat16_flag", osat[1], s1);
    drain();

    // Unsigned 255*255, then a first beat that restarts an open group
    send_beat(8'd255, 8'd255, 24'd0, 1'b1, 1'b1, 1'b0);
    wait_vld(n);
    chk("uns_psum", ops2, 24'd65025);
    send_beat(8'd10, 8'd10, 24'd0, 1'b1, 1'b0, 1'b0);
    send_beat(8'd2, 8'd3, 24'd0, 1'b1, 1'b0, 1'b0);
    send_beat(8'd1, 8'd1, 24'd0, 1'b0, 1'b1, 1'b0);
    wait_vld(n);
    chk("discard_psum", ops0, 24'd7);
    drain();

    // Back-pressure with beats in flight and waiting at the input
    psum_rdy = 1'b0;
    send_beat(8'd9, 8'd9, 24'd0, 1'b1, 1'b1, 1'b0);
    fork
      begin
        for (int k = 1; k <= 6; k++)
          send_beat(8'(k), 8'(k + 1), 24'(k), 1'b1, 1'b1, 1'b0);
      end
      begin
        wait_vld(n);
        for (int c = 0; c < 3; c++) begin
          chk("stall_rdy", rdy[0], 0);
          @(posedge clk); #1;
        end
        psum_rdy = 1'b1;
      end
    join
    drain();

    // Randomised traffic with random back-pressure
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        vld = 1'b0;
        @(posedge clk); #1;
        psum_rdy = ($urandom_range(0, 3) != 0);
      end
      send_beat(8'($urandom), 8'($urandom), 24'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1'b1);
    end
    psum_rdy = 1'b1;
    drain();

    // Reset in the middle of a group
    send_beat(8'd2, 8'd3, 24'd7, 1'b1, 1'b0, 1'b0);
    send_beat(8'd4, 8'd5, 24'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("mrst_vld", ovld, 0);
    chk("mrst_psum0", ops0, 0);
    chk("mrst_psum1", ops1, 0);
    chk("mrst_sat", osat, 0);
    chk("mrst_rdy", rdy, 3'b111);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    send_beat(8'd5, 8'd5, 24'd1, 1'b1, 1'b1, 1'b0);
    wait_vld(n);
    chk("post_rst_lat", n, 5);
    chk("post_rst_psum", ops0, 24'd26);
    drain();

    chk("sb_empty", q0.size() + q1.size() + q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
